// File: rtl/fetch_unit_if.sv
// Bus bundle between the fetch unit, instruction memory and decode.
// The master modport is the fetch unit's view; slave is the environment's view.
interface fetch_unit_if;
  logic        imem_req_valid_out;
  logic        imem_req_ready_in;
  logic [31:0] imem_req_addr_out;
  logic        imem_resp_valid_in;
  logic [31:0] imem_resp_data_in;
  logic        redirect_valid_in;
  logic [31:0] redirect_pc_in;
  logic [31:0] instruction_out;
  logic [31:0] pc_out;
  logic        valid_out;
  logic        ready_in;

  modport master (
    output imem_req_valid_out, imem_req_addr_out, instruction_out, pc_out, valid_out,
    input  imem_req_ready_in, imem_resp_valid_in, imem_resp_data_in, redirect_valid_in,
           redirect_pc_in, ready_in
  );

  modport slave (
    input  imem_req_valid_out, imem_req_addr_out, instruction_out, pc_out, valid_out,
    output imem_req_ready_in, imem_resp_valid_in, imem_resp_data_in, redirect_valid_in,
           redirect_pc_in, ready_in
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch front end: pc-tagged response FIFO, redirect flush with stale-response drop.
// Define FETCH_STATS_EN to add pop/redirect counter outputs.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 4
) (
  input  logic         clk_in,
  input  logic         rst_in,
`ifdef FETCH_STATS_EN
  output logic [31:0]  fetched_count_out,
  output logic [15:0]  redirect_count_out,
`endif
  fetch_unit_if.master bus
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [CW-1:0] occ_q, occ_d, out_q, out_d, drop_q, drop_d;
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d, pw_q, pw_d, pr_q, pr_d;

  logic [31:0] data_mem [DEPTH];
  logic [31:0] pc_mem   [DEPTH];
  logic [31:0] pcq_mem  [DEPTH];

  logic redirect, req_valid, fire, resp_take, push, pop, head_valid;

  assign redirect   = bus.redirect_valid_in;
  assign head_valid = (occ_q != '0);
  // occupancy + outstanding never exceeds DEPTH, so FIFO overflow is impossible
  assign req_valid  = !rst_in && !redirect && ((32'(occ_q) + 32'(out_q)) < DEPTH);
  assign fire       = req_valid && bus.imem_req_ready_in;
  assign resp_take  = bus.imem_resp_valid_in && (out_q != '0);
  assign push       = resp_take && !redirect && (drop_q == '0);
  assign pop        = head_valid && bus.ready_in && !redirect;

  assign bus.imem_req_valid_out = req_valid;
  assign bus.imem_req_addr_out  = fetch_pc_q;
  assign bus.valid_out          = head_valid;
  assign bus.instruction_out    = head_valid ? data_mem[rd_q] : '0;
  assign bus.pc_out             = head_valid ? pc_mem[rd_q] : '0;

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    out_d      = out_q + CW'(fire) - CW'(resp_take);
    drop_d     = drop_q;
    occ_d      = occ_q + CW'(push) - CW'(pop);
    wr_d       = wr_q + AW'(push);
    rd_d       = rd_q + AW'(pop);
    pw_d       = pw_q + AW'(fire);
    pr_d       = pr_q + AW'(resp_take);

    if (redirect) begin
      fetch_pc_d = {bus.redirect_pc_in[31:2], 2'b00};
      // Everything still in flight after this cycle predates the redirect.
      drop_d     = out_q - CW'(resp_take);
      occ_d      = '0;
      wr_d       = '0;
      rd_d       = '0;
    end else begin
      if (fire) begin
        fetch_pc_d = fetch_pc_q + 32'd4;
      end
      if (resp_take && (drop_q != '0)) begin
        drop_d = drop_q - CW'(1);
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      fetch_pc_q <= RESET_PC;
      occ_q      <= '0;
      out_q      <= '0;
      drop_q     <= '0;
      wr_q       <= '0;
      rd_q       <= '0;
      pw_q       <= '0;
      pr_q       <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      occ_q      <= occ_d;
      out_q      <= out_d;
      drop_q     <= drop_d;
      wr_q       <= wr_d;
      rd_q       <= rd_d;
      pw_q       <= pw_d;
      pr_q       <= pr_d;
    end
  end

  // Storage arrays need no reset; pointers and counts qualify every read.
  always_ff @(posedge clk_in) begin
    if (fire) begin
      pcq_mem[pw_q] <= fetch_pc_q;
    end
    if (push) begin
      data_mem[wr_q] <= bus.imem_resp_data_in;
      pc_mem[wr_q]   <= pcq_mem[pr_q];
    end
  end

`ifdef FETCH_STATS_EN
  logic [31:0] fetched_q;
  logic [15:0] redirect_q;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      fetched_q  <= '0;
      redirect_q <= '0;
    end else begin
      if (pop) begin
        fetched_q <= fetched_q + 32'd1;
      end
      if (redirect) begin
        redirect_q <= redirect_q + 16'd1;
      end
    end
  end

  assign fetched_count_out  = fetched_q;
  assign redirect_count_out = redirect_q;
`endif
endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: memory responder model plus expected (pc, instr) queue.
// Define FETCH_STATS_EN to also check the statistics counters.
module tb_fetch_unit;
  localparam int unsigned DEPTH = 4;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] data;
    int          due;
    bit          stale;
  } mem_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] data;
  } sb_t;

  logic clk;
  logic rst;
  fetch_unit_if bus ();
`ifdef FETCH_STATS_EN
  logic [31:0] fetched_count;
  logic [15:0] redirect_count;
`endif

  fetch_unit #(
    .RESET_PC(32'h0000_0000),
    .DEPTH   (DEPTH)
  ) dut (
    .clk_in            (clk),
    .rst_in            (rst),
`ifdef FETCH_STATS_EN
    .fetched_count_out (fetched_count),
    .redirect_count_out(redirect_count),
`endif
    .bus               (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  mem_t        mem_q[$];
  sb_t         sb_q[$];
  int          late_cnt = 0;
  int          cyc = 0;
  int          fires = 0;
  int          pops = 0;
  int          redirs = 0;
  logic [31:0] model_pc = 32'h0;

  bit          rst_k = 1'b0;
  bit          ready_k = 1'b0;
  bit          mem_ready_k = 1'b0;
  bit          resp_en_k = 1'b0;
  bit          redirect_k = 1'b0;
  logic [31:0] redirect_pc_k = 32'h0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s (cycle %0d): got %h expected %h", tag, cyc, got, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] addr);
    if (addr == 32'h0) return 32'h0015_8593;
    if (addr == 32'h4) return 32'h00D6_05B3;
    return {~addr[15:0], addr[15:0]} ^ 32'h5A5A_0000;
  endfunction

  // One clock cycle: drive at negedge, sample 1ns later, update the model, wait for next negedge.
  task automatic cycle();
    mem_t        m;
    bit          resp;
    bit          late;
    bit          exp_req;
    logic [31:0] rdata;
    resp  = 1'b0;
    late  = 1'b0;
    rdata = 32'h0;
    if (resp_en_k) begin
      if (late_cnt > 0) begin
        resp  = 1'b1;
        late  = 1'b1;
        rdata = 32'hDEAD_BEEF;
      end else if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
        resp  = 1'b1;
        rdata = mem_q[0].data;
      end
    end
    rst                    = rst_k;
    bus.imem_req_ready_in  = mem_ready_k;
    bus.ready_in           = ready_k;
    bus.redirect_valid_in  = redirect_k;
    bus.redirect_pc_in     = redirect_pc_k;
    bus.imem_resp_valid_in = resp;
    bus.imem_resp_data_in  = rdata;
    #1;
    exp_req = !rst_k && !redirect_k && ((sb_q.size() + mem_q.size()) < DEPTH);
    check("req_valid", 32'(bus.imem_req_valid_out), 32'(exp_req));
    check("valid_out", 32'(bus.valid_out), 32'(sb_q.size() != 0));
    if (sb_q.size() != 0) begin
      check("pc_out", bus.pc_out, sb_q[0].pc);
      check("instruction_out", bus.instruction_out, sb_q[0].data);
    end
    if (rst_k) begin
      check("reset_pc_out", bus.pc_out, 32'h0);
      check("reset_instruction_out", bus.instruction_out, 32'h0);
      late_cnt = mem_q.size();
      mem_q.delete();
      sb_q.delete();
      model_pc = 32'h0;
      pops     = 0;
      redirs   = 0;
    end else begin
      if (sb_q.size() != 0 && ready_k && !redirect_k) begin
        void'(sb_q.pop_front());
        pops++;
      end
      if (resp) begin
        if (late) begin
          late_cnt--;
        end else begin
          m = mem_q.pop_front();
          if (!redirect_k && !m.stale) sb_q.push_back('{m.pc, m.data});
        end
      end
      if (redirect_k) begin
        foreach (mem_q[i]) mem_q[i].stale = 1'b1;
        sb_q.delete();
        model_pc = {redirect_pc_k[31:2], 2'b00};
        redirs++;
      end
      if (exp_req && mem_ready_k) begin
        check("req_addr", bus.imem_req_addr_out, model_pc);
        mem_q.push_back('{model_pc, mem_word(model_pc), cyc + 1, 1'b0});
        model_pc = model_pc + 32'd4;
        fires++;
      end
    end
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic redirect_to(input logic [31:0] pc);
    redirect_k    = 1'b1;
    redirect_pc_k = pc;
    cycle();
    redirect_k    = 1'b0;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  int f0;

  initial begin
    rst                    = 1'b1;
    bus.imem_req_ready_in  = 1'b0;
    bus.ready_in           = 1'b0;
    bus.redirect_valid_in  = 1'b0;
    bus.redirect_pc_in     = 32'h0;
    bus.imem_resp_valid_in = 1'b0;
    bus.imem_resp_data_in  = 32'h0;
    @(posedge clk);
    @(negedge clk);

    // Reset state
    rst_k = 1'b1;
    cycle();
    rst_k = 1'b0;
`ifdef FETCH_STATS_EN
    check("fetched_count_reset", fetched_count, 32'h0);
    check("redirect_count_reset", 32'(redirect_count), 32'h0);
`endif

    // Decode stalled: only DEPTH requests may fire, head stays stable
    mem_ready_k = 1'b1;
    resp_en_k   = 1'b1;
    ready_k     = 1'b0;
    f0 = fires;
    run(10);
    check("stall_fires", 32'(fires - f0), 32'(DEPTH));
    ready_k = 1'b1;
    run(12);

    // Redirect with 2 outstanding and 1 buffered entry
    mem_ready_k = 1'b0;
    run(6);
    ready_k     = 1'b0;
    resp_en_k   = 1'b0;
    mem_ready_k = 1'b1;
    run(3);
    mem_ready_k = 1'b0;
    resp_en_k   = 1'b1;
    run(1);
    check("pre_redirect_buffered", 32'(bus.valid_out), 32'h1);
    resp_en_k = 1'b0;
    redirect_to(32'h0000_0102);
    ready_k     = 1'b1;
    mem_ready_k = 1'b1;
    resp_en_k   = 1'b1;
    run(12);

    // Redirect in the same cycle as a response
    mem_ready_k = 1'b0;
    run(6);
    mem_ready_k = 1'b1;
    resp_en_k   = 1'b0;
    run(3);
    resp_en_k = 1'b1;
    redirect_to(32'h0000_0200);
    run(12);

    // Address wrap
    redirect_to(32'hFFFF_FFFC);
    run(10);

    // Reset with 3 requests outstanding
    mem_ready_k = 1'b0;
    run(6);
`ifdef FETCH_STATS_EN
    check("fetched_count", fetched_count, 32'(pops));
    check("redirect_count", 32'(redirect_count), 32'(redirs));
`endif
    mem_ready_k = 1'b1;
    resp_en_k   = 1'b0;
    run(3);
    mem_ready_k = 1'b0;
    rst_k = 1'b1;
    cycle();
    rst_k = 1'b0;
`ifdef FETCH_STATS_EN
    check("fetched_count_rst2", fetched_count, 32'h0);
    check("redirect_count_rst2", 32'(redirect_count), 32'h0);
`endif
    resp_en_k = 1'b1;
    run(5);
    check("late_resp_consumed", 32'(late_cnt), 32'h0);
    mem_ready_k = 1'b1;
    run(10);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
